// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//
// Handshake bundle for serial_subtractor: an operand channel (in_valid /
// in_ready / a / b) and a result channel (out_valid / out_ready / diff /
// borrow / overflow).
//
// Parameters:
//   WIDTH      operand and result width in bits (2..64)
//
// Modports:
//   master     producer of operands and consumer of results (drives
//              in_valid, a, b, out_ready)
//   slave      the subtractor itself (drives in_ready, out_valid, diff,
//              borrow, overflow)
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor computing (a - b) mod 2^WIDTH, one bit per clock,
// LSB first, with a single borrow flop. An operation occupies the block for
// WIDTH+2 cycles: one accept edge, WIDTH RUN edges, one result handshake.
//
// Parameters:
//   WIDTH      operand and result width in bits (2..64)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; aborts any operation in flight
//   bus        serial_subtractor_if.slave
//                in_valid/in_ready  operand handshake (in_ready only in IDLE)
//                a, b               minuend / subtrahend
//                out_valid/out_ready result handshake (out_valid only in DONE)
//                diff               (a - b) mod 2^WIDTH
//                borrow             1 iff a < b unsigned
//                overflow           two's-complement overflow of a - b
//
// Configuration:
//   SERIAL_SUBTRACTOR_OVERFLOW_EN  when defined, overflow is computed from
//                                  the operand MSBs captured at acceptance;
//                                  otherwise overflow is tied to 0.
//
// All outputs come from registers or decoded state; no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_subtractor_if.slave   bus
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q;

    logic             accept;
    logic             running;
    logic             last_bit;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             bout_bit;

    assign accept   = bus.in_valid && (state_q == IDLE);
    assign running  = (state_q == RUN);
    assign last_bit = running && (cnt_q == LAST_BIT);

    // One full-subtractor cell, fed from the LSB of the operand shifters.
    assign a_bit    = a_sh[0];
    assign b_bit    = b_sh[0];
    assign d_bit    = a_bit ^ b_bit ^ bin_q;
    assign bout_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)        state_d = RUN;
            RUN:     if (last_bit)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand shifters
    // ------------------------------------------------------------------
    // NOTE: the operand shifters carry no reset: they are always loaded on
    // acceptance before any bit of them is consumed, so reset would only
    // add fan-out to the reset net.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
        end else if (running) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
        end
    end

    // ------------------------------------------------------------------
    // Result, borrow and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            diff_q <= '0;
            bin_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            diff_q <= '0;
            bin_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (running) begin
            // Enter from the MSB side: after WIDTH shifts bit i sits at diff[i].
            diff_q <= {d_bit, diff_q[WIDTH-1:1]};
            bin_q  <= bout_bit;
            // Hold on the last bit so the counter never wraps.
            if (!last_bit) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Signed overflow
    // ------------------------------------------------------------------
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
        end
    end

    // On the final RUN edge d_bit is the result MSB: overflow when the
    // operand signs differ and the result sign differs from the minuend.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
        end
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = bin_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor at WIDTH=8. Inputs are driven and
// outputs sampled on the falling clock edge. Expected overflow follows
// SERIAL_SUBTRACTOR_OVERFLOW_EN as seen by this compilation.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Present operands at a falling edge; returns at the falling edge after
    // the accept edge with in_valid dropped.
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count falling edges until out_valid, starting from 'start'; bounded.
    task automatic wait_done(input int start, output int n);
        n = start;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, want 0", bus.out_valid); end
        n_checks++; if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff: got %h, want 00", bus.diff); end
        n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b, want 0", bus.borrow); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, want 0", bus.overflow); end
    endtask

    // 100 - 37 = 63, latency and in_ready timing.
    task automatic test_basic();
        int n;
        bus.out_ready = 1'b1;
        accept(8'd100, 8'd37);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_fall: got %b, want 0", bus.in_ready); end
        wait_done(0, n);
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d, want 8", n); end
        n_checks++; if (bus.diff !== 8'd63) begin n_fail++; $display("FAIL basic_diff: got %0d, want 63", bus.diff); end
        n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL basic_borrow: got %b, want 0", bus.borrow); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b, want 0", bus.overflow); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_done: got %b, want 0", bus.in_ready); end
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_rise: got %b, want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_valid_drop: got %b, want 0", bus.out_valid); end
    endtask

    // 37 - 100 wraps to 0xC1 with borrow, no signed overflow.
    task automatic test_borrow();
        int n;
        accept(8'd37, 8'd100);
        wait_done(0, n);
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL borrow_latency: got %0d, want 8", n); end
        n_checks++; if (bus.diff !== 8'hC1) begin n_fail++; $display("FAIL borrow_diff: got %h, want c1", bus.diff); end
        n_checks++; if (bus.borrow !== 1'b1) begin n_fail++; $display("FAIL borrow_borrow: got %b, want 1", bus.borrow); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL borrow_overflow: got %b, want 0", bus.overflow); end
        @(negedge clk);
    endtask

    // -128 - 1 overflows signed: 0x7F, no unsigned borrow.
    task automatic test_overflow();
        int n;
        accept(8'h80, 8'h01);
        wait_done(0, n);
        n_checks++; if (bus.diff !== 8'h7F) begin n_fail++; $display("FAIL ovf_diff: got %h, want 7f", bus.diff); end
        n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL ovf_borrow: got %b, want 0", bus.borrow); end
        n_checks++; if (bus.overflow !== OVF_EN) begin n_fail++; $display("FAIL ovf_overflow: got %b, want %b", bus.overflow, OVF_EN); end
        @(negedge clk);
    endtask

    // 0xFF - 0xFF with an in_valid pulse carrying other operands mid-RUN.
    task automatic test_ignore_in_valid();
        int n;
        accept(8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 8'h10;
        bus.b        = 8'h55;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(3, n);
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL ignore_latency: got %0d, want 8", n); end
        n_checks++; if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL ignore_diff: got %h, want 00", bus.diff); end
        n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL ignore_borrow: got %b, want 0", bus.borrow); end
        @(negedge clk);
    endtask

    // 200 - 50 = 150 held through 5 cycles of backpressure.
    task automatic test_backpressure();
        int n;
        bus.out_ready = 1'b0;
        accept(8'd200, 8'd50);
        wait_done(0, n);
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL bp_latency: got %0d, want 8", n); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b, want 1", i, bus.out_valid); end
            n_checks++; if (bus.diff !== 8'd150) begin n_fail++; $display("FAIL bp_diff[%0d]: got %0d, want 150", i, bus.diff); end
            n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL bp_borrow[%0d]: got %b, want 0", i, bus.borrow); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b, want 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b, want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b, want 0", bus.out_valid); end
    endtask

    // Reset after three RUN edges, then a clean 5 - 3.
    task automatic test_reset_mid();
        int n;
        accept(8'd9, 8'd4);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b, want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b, want 0", bus.out_valid); end
        n_checks++; if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL mid_diff: got %h, want 00", bus.diff); end
        accept(8'd5, 8'd3);
        wait_done(0, n);
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL mid_latency: got %0d, want 8", n); end
        n_checks++; if (bus.diff !== 8'd2) begin n_fail++; $display("FAIL mid_new_diff: got %0d, want 2", bus.diff); end
        n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL mid_new_borrow: got %b, want 0", bus.borrow); end
        @(negedge clk);
    endtask

    // Two operations accepted as soon as in_ready returns.
    task automatic test_back_to_back();
        int n;
        accept(8'h01, 8'h02);
        wait_done(0, n);
        n_checks++; if (bus.diff !== 8'hFF) begin n_fail++; $display("FAIL b2b0_diff: got %h, want ff", bus.diff); end
        n_checks++; if (bus.borrow !== 1'b1) begin n_fail++; $display("FAIL b2b0_borrow: got %b, want 1", bus.borrow); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL b2b0_overflow: got %b, want 0", bus.overflow); end
        @(negedge clk);
        accept(8'h7F, 8'hFF);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b1_accepted: in_ready got %b, want 0", bus.in_ready); end
        wait_done(0, n);
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL b2b1_latency: got %0d, want 8", n); end
        n_checks++; if (bus.diff !== 8'h80) begin n_fail++; $display("FAIL b2b1_diff: got %h, want 80", bus.diff); end
        n_checks++; if (bus.borrow !== 1'b1) begin n_fail++; $display("FAIL b2b1_borrow: got %b, want 1", bus.borrow); end
        n_checks++; if (bus.overflow !== OVF_EN) begin n_fail++; $display("FAIL b2b1_overflow: got %b, want %b", bus.overflow, OVF_EN); end
        @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_ignore_in_valid();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
